mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Sequencing controller for the MEM pipeline stage of the 5-stage MIPS core. It sits between the EX/MEM register and the external data-memory bus. It turns load/store requests into single-beat bus transactions with big-endian byte-lane selects, and stalls the pipeline until the bus acknowledges. It formats load data (byte/half/word, signed or unsigned) into the writeback fields; non-memory instructions pass straight through.

Parameters:
TIMEOUT, 16, max cycles in BUS waiting for bus_ack_i before abort (>=2)
CNT_W, 5, width of timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
mem_req_i  in  1  instruction in MEM is a load or store
mem_we_i  in  1  1 = store, 0 = load
mem_size_i  in  2  00 byte, 01 half, 10 word (11 treated as word)
mem_sign_i  in  1  load sign-extend enable
mem_addr_i  in  32  effective address
mem_wdata_i  in  32  store data, right-justified
wd_i  in  5  destination register address
wreg_i  in  1  register write enable from EX
wdata_i  in  32  ALU result, used for non-memory instructions
bus_req_o  out  1  bus request, held until ack
bus_we_o  out  1  bus write
bus_addr_o  out  32  word-aligned address ({mem_addr_i[31:2],2'b00})
bus_sel_o  out  4  byte-lane enables; bit3 = bits[31:24]
bus_wdata_o  out  32  store data replicated onto lanes
bus_rdata_i  in  32  read data
bus_ack_i  in  1  single-cycle acknowledge
stallreq_o  out  1  stall request to pipeline controller
misalign_o  out  1  address-error pulse
bus_err_o  out  1  timeout-abort pulse
wd_o  out  5  writeback register address
wreg_o  out  1  writeback enable
wdata_o  out  32  writeback data

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, counter=0, load-data register=0. While rst=1, all outputs are forced to 0: bus_req_o, stallreq_o, wreg_o, wdata_o=0, wd_o=5'b0, misalign_o, bus_err_o. Reset mid-BUS drops bus_req_o in the same cycle and abandons the transaction.
- States: IDLE, BUS, DONE.
- Misaligned request (half with addr[0]=1, or word with addr[1:0]!=0), evaluated combinationally in IDLE:
  - misalign_o=1 for that cycle; wreg_o=0; no bus request; no stall; state stays IDLE.
- IDLE:
  - mem_req_i=0: pass-through, wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i, stallreq_o=0.
  - Aligned mem_req_i=1: bus_req_o and stallreq_o asserted combinationally in the same cycle; next state BUS; counter cleared.
- BUS:
  - bus_req_o=1 and stallreq_o=1; address, sel, we and wdata held stable from the held inputs.
  - Counter increments each cycle.
  - bus_ack_i=1: on a load, capture formatted rdata; next state DONE.
  - Counter reaching TIMEOUT-1 without ack: next state DONE with error flag set.
  - Ack on the same cycle as timeout: ack wins, no error.
- DONE (exactly 1 cycle):
  - bus_req_o=0, stallreq_o=0; pipeline advances on this cycle; next state IDLE.
  - Load: wreg_o=wreg_i, wd_o=wd_i, wdata_o=captured data.
  - Store: wreg_o=0.
  - Error: bus_err_o=1, wreg_o=0.
- Latency: an aligned access with ack on the k-th BUS cycle stalls for k+1 cycles; minimum stall is 2 (ack on first BUS cycle).
- Byte lanes, big-endian:
  - Byte at offset n: sel=4'b1000>>n; wdata replicates {4{b}}.
  - Half: offset 0 gives sel 1100, offset 2 gives 0011; wdata={2{h}}.
  - Word: sel=1111.
  - Load extraction uses the same lanes; sign bit taken when mem_sign_i=1, otherwise zero-extended.
- bus_sel_o=0 and bus_we_o=0 whenever bus_req_o=0.

Test Plan:
- ALU op (mem_req_i=0, wd_i=5, wreg_i=1, wdata_i=0x1234): same-cycle wd_o=5, wreg_o=1, wdata_o=0x1234, stallreq_o=0, bus_req_o=0.
- Signed byte load, addr=0x1001, rdata=0x11F0_2233, ack in 1st BUS cycle: sel=0100, addr=0x1000, stallreq_o high for 2 cycles, DONE wdata_o=0xFFFF_FFF0.
- Unsigned half load at addr=0x2002 with rdata=0xAAAA_8001, ack after 3 BUS cycles: sel=0011, 4 stall cycles, wdata_o=0x0000_8001.
- Byte store 0x5A at addr=0x3003: bus_we_o=1, sel=0001, bus_wdata_o=0x5A5A_5A5A, wreg_o=0 in DONE.
- Word load addr=0x4002: misalign_o=1 for 1 cycle, no bus_req_o, no stall, wreg_o=0. Separately, no ack with TIMEOUT=16: 16 BUS cycles, then bus_err_o=1 for 1 cycle, then IDLE.
- rst asserted during the 2nd BUS cycle: next cycle bus_req_o=0, stallreq_o=0, all outputs 0; after rst release, the next request starts cleanly from IDLE.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: turns load/store requests into single-beat big-endian bus
// transactions, stalls the pipeline until ack or timeout, and formats load data for writeback.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_sign_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        stallreq_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o
);

    typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        load_q;
    logic               err_q;

    logic               misalign;
    logic [3:0]         lane_sel;
    logic [31:0]        lane_wdata;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [31:0]        load_fmt;
    logic               bus_active;

    assign misalign = (mem_size_i == 2'b01 && mem_addr_i[0]) ||
                      (mem_size_i[1] && mem_addr_i[1:0] != 2'b00);

    // Big-endian lanes: offset 0 lives in bits [31:24].
    always_comb begin
        lane_sel   = 4'b1111;
        lane_wdata = mem_wdata_i;
        unique case (mem_size_i)
            2'b00: begin
                lane_sel   = 4'b1000 >> mem_addr_i[1:0];
                lane_wdata = {4{mem_wdata_i[7:0]}};
            end
            2'b01: begin
                lane_sel   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
                lane_wdata = {2{mem_wdata_i[15:0]}};
            end
            default: begin
                lane_sel   = 4'b1111;
                lane_wdata = mem_wdata_i;
            end
        endcase
    end

    always_comb begin
        rd_byte = bus_rdata_i[31:24];
        unique case (mem_addr_i[1:0])
            2'b00: rd_byte = bus_rdata_i[31:24];
            2'b01: rd_byte = bus_rdata_i[23:16];
            2'b10: rd_byte = bus_rdata_i[15:8];
            default: rd_byte = bus_rdata_i[7:0];
        endcase
        rd_half = mem_addr_i[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];
        unique case (mem_size_i)
            2'b00:   load_fmt = {{24{mem_sign_i & rd_byte[7]}}, rd_byte};
            2'b01:   load_fmt = {{16{mem_sign_i & rd_half[15]}}, rd_half};
            default: load_fmt = bus_rdata_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            load_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    err_q <= 1'b0;
                    if (mem_req_i && !misalign) begin
                        state_q <= StBus;
                    end
                end
                StBus: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Ack takes priority over a coincident timeout.
                    if (bus_ack_i) begin
                        if (!mem_we_i) begin
                            load_q <= load_fmt;
                        end
                        err_q   <= 1'b0;
                        state_q <= StDone;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= StDone;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        bus_active = 1'b0;
        stallreq_o = 1'b0;
        misalign_o = 1'b0;
        bus_err_o  = 1'b0;
        wd_o       = 5'b0;
        wreg_o     = 1'b0;
        wdata_o    = 32'b0;
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    if (!mem_req_i) begin
                        wd_o    = wd_i;
                        wreg_o  = wreg_i;
                        wdata_o = wdata_i;
                    end else if (misalign) begin
                        misalign_o = 1'b1;
                        wd_o       = wd_i;
                        wdata_o    = wdata_i;
                    end else begin
                        bus_active = 1'b1;
                        stallreq_o = 1'b1;
                    end
                end
                StBus: begin
                    bus_active = 1'b1;
                    stallreq_o = 1'b1;
                end
                default: begin
                    if (err_q) begin
                        bus_err_o = 1'b1;
                    end else if (!mem_we_i) begin
                        wd_o    = wd_i;
                        wreg_o  = wreg_i;
                        wdata_o = load_q;
                    end
                end
            endcase
        end
    end

    assign bus_req_o   = bus_active;
    assign bus_we_o    = bus_active & mem_we_i;
    assign bus_addr_o  = bus_active ? {mem_addr_i[31:2], 2'b00} : 32'b0;
    assign bus_sel_o   = bus_active ? lane_sel : 4'b0;
    assign bus_wdata_o = bus_active ? lane_wdata : 32'b0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: pass-through, loads, store, misalign, timeout, reset.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_i, mem_we_i, mem_sign_i, wreg_i, bus_ack_i;
    logic [1:0]  mem_size_i;
    logic [31:0] mem_addr_i, mem_wdata_i, wdata_i, bus_rdata_i;
    logic [4:0]  wd_i;
    logic        bus_req_o, bus_we_o, stallreq_o, misalign_o, bus_err_o, wreg_o;
    logic [31:0] bus_addr_o, bus_wdata_o, wdata_o;
    logic [3:0]  bus_sel_o;
    logic [4:0]  wd_o;

    int checks = 0;
    int errors = 0;
    int stalls;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
        .mem_sign_i(mem_sign_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
        .bus_ack_i(bus_ack_i), .stallreq_o(stallreq_o), .misalign_o(misalign_o),
        .bus_err_o(bus_err_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after inputs are applied in IDLE; returns at the DONE cycle's negedge.
    // ack_on = BUS cycle index carrying the ack (0 = never).
    task automatic run_access(input int ack_on, output int n_stall);
        n_stall = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (!stallreq_o) return;
            n_stall++;
            @(posedge clk);
            #1;
            bus_ack_i = (ack_on != 0 && cyc + 1 == ack_on);
        end
        n_stall = -1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        mem_req_i = 0; mem_we_i = 0; mem_sign_i = 0; wreg_i = 0; bus_ack_i = 0;
        mem_size_i = 2'b00; mem_addr_i = 0; mem_wdata_i = 0; wdata_i = 32'h55; wd_i = 5'd3;
        bus_rdata_i = 0;
        next_cycle();
        next_cycle();
        wreg_i = 1; mem_req_i = 1; mem_addr_i = 32'h100;
        @(negedge clk);
        chk("rst_bus_req", 32'(bus_req_o), 32'd0);
        chk("rst_stall", 32'(stallreq_o), 32'd0);
        chk("rst_wreg", 32'(wreg_o), 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_wd", 32'(wd_o), 32'd0);

        // ALU pass-through
        next_cycle();
        rst = 0; mem_req_i = 0; wd_i = 5'd5; wreg_i = 1; wdata_i = 32'h1234;
        @(negedge clk);
        chk("alu_wd", 32'(wd_o), 32'd5);
        chk("alu_wreg", 32'(wreg_o), 32'd1);
        chk("alu_wdata", wdata_o, 32'h1234);
        chk("alu_stall", 32'(stallreq_o), 32'd0);
        chk("alu_bus_req", 32'(bus_req_o), 32'd0);
        chk("alu_sel", 32'(bus_sel_o), 32'd0);

        // Signed byte load, ack on first BUS cycle
        next_cycle();
        mem_req_i = 1; mem_we_i = 0; mem_size_i = 2'b00; mem_sign_i = 1;
        mem_addr_i = 32'h1001; wd_i = 5'd7; wreg_i = 1; bus_rdata_i = 32'h11F0_2233;
        #2;
        chk("lb_req", 32'(bus_req_o), 32'd1);
        chk("lb_sel", 32'(bus_sel_o), 32'b0100);
        chk("lb_addr", bus_addr_o, 32'h1000);
        chk("lb_we", 32'(bus_we_o), 32'd0);
        run_access(1, stalls);
        chk("lb_stalls", 32'(stalls), 32'd2);
        chk("lb_done_req", 32'(bus_req_o), 32'd0);
        chk("lb_wreg", 32'(wreg_o), 32'd1);
        chk("lb_wd", 32'(wd_o), 32'd7);
        chk("lb_wdata", wdata_o, 32'hFFFF_FFF0);

        // Unsigned half load, ack on third BUS cycle
        next_cycle();
        mem_size_i = 2'b01; mem_sign_i = 0; mem_addr_i = 32'h2002; bus_rdata_i = 32'hAAAA_8001;
        #2;
        chk("lh_sel", 32'(bus_sel_o), 32'b0011);
        chk("lh_addr", bus_addr_o, 32'h2000);
        run_access(3, stalls);
        chk("lh_stalls", 32'(stalls), 32'd4);
        chk("lh_wdata", wdata_o, 32'h0000_8001);

        // Signed half load at offset 0
        next_cycle();
        mem_sign_i = 1; mem_addr_i = 32'h2000; bus_rdata_i = 32'h8001_1234;
        #2;
        chk("lhs_sel", 32'(bus_sel_o), 32'b1100);
        run_access(1, stalls);
        chk("lhs_wdata", wdata_o, 32'hFFFF_8001);

        // Byte store
        next_cycle();
        mem_we_i = 1; mem_size_i = 2'b00; mem_sign_i = 0; mem_addr_i = 32'h3003;
        mem_wdata_i = 32'h0000_005A;
        #2;
        chk("sb_we", 32'(bus_we_o), 32'd1);
        chk("sb_sel", 32'(bus_sel_o), 32'b0001);
        chk("sb_wdata", bus_wdata_o, 32'h5A5A_5A5A);
        run_access(2, stalls);
        chk("sb_stalls", 32'(stalls), 32'd3);
        chk("sb_wreg", 32'(wreg_o), 32'd0);
        chk("sb_done_we", 32'(bus_we_o), 32'd0);

        // Misaligned word load
        next_cycle();
        mem_we_i = 0; mem_size_i = 2'b10; mem_addr_i = 32'h4002;
        @(negedge clk);
        chk("mis_flag", 32'(misalign_o), 32'd1);
        chk("mis_req", 32'(bus_req_o), 32'd0);
        chk("mis_stall", 32'(stallreq_o), 32'd0);
        chk("mis_wreg", 32'(wreg_o), 32'd0);
        next_cycle();
        mem_req_i = 0;
        @(negedge clk);
        chk("mis_after_flag", 32'(misalign_o), 32'd0);
        chk("mis_after_stall", 32'(stallreq_o), 32'd0);

        // Timeout: no ack
        next_cycle();
        mem_req_i = 1; mem_addr_i = 32'h5000;
        run_access(0, stalls);
        chk("to_stalls", 32'(stalls), 32'd17);
        chk("to_err", 32'(bus_err_o), 32'd1);
        chk("to_wreg", 32'(wreg_o), 32'd0);
        next_cycle();
        mem_req_i = 0;
        @(negedge clk);
        chk("to_err_after", 32'(bus_err_o), 32'd0);
        chk("to_idle_stall", 32'(stallreq_o), 32'd0);

        // Reset during second BUS cycle
        next_cycle();
        mem_req_i = 1; mem_addr_i = 32'h6000; wdata_i = 32'h77;
        next_cycle();
        next_cycle();
        rst = 1;
        @(negedge clk);
        chk("rb_req", 32'(bus_req_o), 32'd0);
        chk("rb_stall", 32'(stallreq_o), 32'd0);
        chk("rb_wdata", wdata_o, 32'd0);
        chk("rb_sel", 32'(bus_sel_o), 32'd0);
        next_cycle();
        rst = 0; mem_req_i = 0;
        @(negedge clk);
        chk("rb_idle_stall", 32'(stallreq_o), 32'd0);
        chk("rb_idle_wdata", wdata_o, 32'h77);
        next_cycle();
        mem_req_i = 1; mem_size_i = 2'b00; mem_sign_i = 0; mem_addr_i = 32'h7000;
        bus_rdata_i = 32'h8000_0000;
        #2;
        chk("rb_new_sel", 32'(bus_sel_o), 32'b1000);
        run_access(1, stalls);
        chk("rb_new_stalls", 32'(stalls), 32'd2);
        chk("rb_new_wdata", wdata_o, 32'h0000_0080);
        chk("rb_new_err", 32'(bus_err_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
